// File: rtl/term_pkg.sv
// Shared terminal types: character width, ASCII codes and source ids.
// Used by term_key_arbiter (optional drop counters: TERM_ARB_DROP_CNT_EN).
package term_pkg;

  localparam int CHAR_W = 8;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_BS = 8'h08;

  typedef enum logic [0:0] {
    CH_PS2  = 1'b0,
    CH_UART = 1'b1
  } ch_e;

  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/term_key_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request after the last grant.
// Sub-module of term_key_arbiter (TERM_ARB_DROP_CNT_EN not used here).
module rr_arbiter
  import term_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            c;
  logic [IW-1:0] ci;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    ci  = '0;
    // scan N slots starting one past the previous winner
    for (int k = 1; k <= N; k++) begin
      c = int'(last) + k;
      if (c >= N) c = c - N;
      ci = IW'(c);
      if (!any && req[ci]) begin
        any     = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/term_key_arbiter.sv
// Multi-source keystroke arbiter: pending slots, round-robin, tagged FIFO.
// Define TERM_ARB_DROP_CNT_EN to add per-channel saturating drop counters.
module term_key_arbiter
  import term_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int DW     = CHAR_W,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_CH*DW-1:0]           in_dat,
  input  logic [N_CH-1:0]              in_wen,
  output logic [DW-1:0]                out_dat,
  output logic [src_width(N_CH)-1:0]   out_src,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH):0]       fill,
  output logic                         overflow,
  input  logic                         clr_drop
`ifdef TERM_ARB_DROP_CNT_EN
  ,
  output logic [N_CH*DROP_W-1:0]       drop_cnt
`endif
);

  localparam int SRC_W = src_width(N_CH);
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = AW + 1;
  localparam int EW    = SRC_W + DW;

  if (N_CH < 1 || DEPTH < 2 || DROP_W < 1) begin : g_bad_cfg
    $error("term_key_arbiter: bad parameters");
  end

  logic [N_CH-1:0]  pend;
  logic [DW-1:0]    pdat [N_CH];
  logic [SRC_W-1:0] last_grant;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [FW-1:0]    cnt;

  logic             full;
  logic             pop;
  logic             can_push;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  gnt;
  logic [SRC_W-1:0] gidx;
  logic             push;
  logic [N_CH-1:0]  drop;

  assign full      = (cnt == FW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign pop       = out_valid & out_ready;
  // a full FIFO still takes a push when the head leaves this cycle
  assign can_push  = !full || pop;
  assign req       = pend & {N_CH{can_push}};
  assign drop      = in_wen & pend & ~gnt;

  rr_arbiter #(
    .N  (N_CH),
    .IW (SRC_W)
  ) u_arb (
    .req  (req),
    .last (last_grant),
    .gnt  (gnt),
    .idx  (gidx),
    .any  (push)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend       <= '0;
      last_grant <= SRC_W'(N_CH - 1);
      for (int i = 0; i < N_CH; i++) pdat[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (in_wen[i] && (!pend[i] || gnt[i]))
          pdat[i] <= in_dat[i*DW +: DW];
        pend[i] <= in_wen[i] | (pend[i] & ~gnt[i]);
      end
      if (push) last_grant <= gidx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {gidx, pdat[gidx]};
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + FW'(1);
        2'b01:   cnt <= cnt - FW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign out_dat = mem[rptr][DW-1:0];
  assign out_src = mem[rptr][EW-1:DW];
  assign fill    = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)        overflow <= 1'b0;
    else if (clr_drop) overflow <= 1'b0;
    else if (|drop)    overflow <= 1'b1;
  end

`ifdef TERM_ARB_DROP_CNT_EN
  logic [DROP_W-1:0] dcnt [N_CH];

  always_ff @(posedge clk) begin
    if (!rst_n || clr_drop) begin
      for (int i = 0; i < N_CH; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++)
        if (drop[i] && dcnt[i] != {DROP_W{1'b1}})
          dcnt[i] <= dcnt[i] + DROP_W'(1);
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < N_CH; i++)
      drop_cnt[i*DROP_W +: DROP_W] = dcnt[i];
  end
`endif

endmodule

// File: tb/tb_term_key_arbiter.sv
// Scoreboard bench for term_key_arbiter; drop counter checks run only
// when TERM_ARB_DROP_CNT_EN is defined (DROP_W=2 to reach saturation).
module tb_term_key_arbiter;
  import term_pkg::*;

  localparam int N_CH   = 2;
  localparam int DW     = 8;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 2;

  logic                   clk;
  logic                   rst_n;
  logic [N_CH*DW-1:0]     in_dat;
  logic [N_CH-1:0]        in_wen;
  logic [DW-1:0]          out_dat;
  logic [0:0]             out_src;
  logic                   out_valid;
  logic                   out_ready;
  logic [3:0]             fill;
  logic                   overflow;
  logic                   clr_drop;
`ifdef TERM_ARB_DROP_CNT_EN
  logic [N_CH*DROP_W-1:0] drop_cnt;
`endif

  term_key_arbiter #(
    .N_CH   (N_CH),
    .DW     (DW),
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_dat    (in_dat),
    .in_wen    (in_wen),
    .out_dat   (out_dat),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill      (fill),
    .overflow  (overflow),
    .clr_drop  (clr_drop)
`ifdef TERM_ARB_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] exp_q [$];
  logic [8:0] sb_exp;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // monitor: every accepted head must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_extra: got %0h want none", {out_src, out_dat});
      end else begin
        sb_exp = exp_q.pop_front();
        chk("sb_order", 32'({out_src, out_dat}), 32'(sb_exp));
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input int ch, input logic [7:0] d, input bit exp);
    in_wen = '0;
    in_wen[ch] = 1'b1;
    in_dat[ch*DW +: DW] = d;
    if (exp) exp_q.push_back({ch[0], d});
  endtask

  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && k < 64) begin
      cyc();
      k++;
    end
    if (k >= 64) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d left want 0", exp_q.size());
    end
    chk("drain_fill", 32'(fill), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_wen = 2'b11;
    in_dat = 16'h5A5A;
    out_ready = 1'b0;
    clr_drop = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    in_wen = '0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_dat", 32'(out_dat), 32'd0);
    chk("rst_src", 32'(out_src), 32'd0);
`ifdef TERM_ARB_DROP_CNT_EN
    chk("rst_dcnt", 32'(drop_cnt), 32'd0);
`endif
    cyc(3);
    chk("rst_no_pend", 32'(out_valid), 32'd0);

    // single character, two-cycle latency
    put(1, 8'h41, 1);
    cyc();
    in_wen = '0;
    chk("single_lat1", 32'(out_valid), 32'd0);
    cyc();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_dat", 32'(out_dat), 32'h41);
    chk("single_src", 32'(out_src), 32'd1);
    chk("single_fill", 32'(fill), 32'd1);
    out_ready = 1'b1;
    cyc();
    chk("single_pop", 32'(fill), 32'd0);

    // contention: both channels, two bursts
    in_wen = 2'b11;
    in_dat = 16'h3231;
    exp_q.push_back({1'b0, 8'h31});
    exp_q.push_back({1'b1, 8'h32});
    cyc();
    in_wen = '0;
    cyc();
    in_wen = 2'b11;
    in_dat = 16'h3433;
    exp_q.push_back({1'b0, 8'h33});
    exp_q.push_back({1'b1, 8'h34});
    cyc();
    in_wen = '0;
    drain();
    chk("cont_no_ovf", 32'(overflow), 32'd0);

    // full FIFO, one held in pend, one dropped
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      put(0, 8'(8'h60 + i), i < 9);
      cyc();
    end
    in_wen = '0;
    chk("full_fill", 32'(fill), 32'd8);
    chk("full_ovf", 32'(overflow), 32'd1);
    chk("full_head", 32'(out_dat), 32'h60);
`ifdef TERM_ARB_DROP_CNT_EN
    chk("full_dcnt0", 32'(drop_cnt[1:0]), 32'd1);
    chk("full_dcnt1", 32'(drop_cnt[3:2]), 32'd0);
`endif
    cyc(2);
    chk("stall_fill", 32'(fill), 32'd8);
    chk("stall_head", 32'(out_dat), 32'h60);
    drain();

    // full with simultaneous push/pop across pointer wrap
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      put(1, 8'(8'h80 + i), 1);
      cyc();
    end
    chk("wrap_full", 32'(fill), 32'd8);
    out_ready = 1'b1;
    for (int i = 9; i < 12; i++) begin
      put(1, 8'(8'h80 + i), 1);
      cyc();
      chk("wrap_fill", 32'(fill), 32'd8);
    end
    in_wen = '0;
    cyc();
    chk("wrap_last", 32'(fill), 32'd8);
    drain();
    chk("wrap_no_ovf_new", 32'(overflow), 32'd1);

    // repeated drops on ch1, then clear racing a new drop
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      put(0, 8'(8'h90 + i), 1);
      cyc();
    end
    for (int i = 0; i < 6; i++) begin
      put(1, 8'(8'hA0 + i), i == 0);
      cyc();
    end
    chk("sat_ovf", 32'(overflow), 32'd1);
`ifdef TERM_ARB_DROP_CNT_EN
    chk("sat_dcnt1", 32'(drop_cnt[3:2]), 32'd3);
    chk("sat_dcnt0", 32'(drop_cnt[1:0]), 32'd1);
`endif
    clr_drop = 1'b1;
    put(1, 8'hAF, 0);
    cyc();
    clr_drop = 1'b0;
    in_wen = '0;
    chk("clr_ovf", 32'(overflow), 32'd0);
`ifdef TERM_ARB_DROP_CNT_EN
    chk("clr_dcnt", 32'(drop_cnt), 32'd0);
`endif
    drain();

    // reset in the middle of traffic
    out_ready = 1'b0;
    put(0, 8'h55, 0);
    cyc();
    put(1, 8'h66, 0);
    cyc();
    in_wen = '0;
    cyc();
    chk("mid_fill", 32'(fill), 32'd2);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid_rst_fill", 32'(fill), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    cyc(3);
    chk("mid_rst_quiet", 32'(out_valid), 32'd0);

    put(0, ASCII_CR, 1);
    cyc();
    in_wen = '0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
